uart_tx_arbiter: RTL and testbench

- Shares the single uart_tx serializer among N_REQ byte-producing requesters, such as the rx-echo path, a status reporter, and a debug dumper.
- Arbitration is round-robin. Each requester uses a valid/ready handshake; the block owns tx_start and tx_data toward uart_tx.
- It sequences one frame at a time: accept a byte, pulse tx_start, wait for tx_done_tick.
- A watchdog recovers if tx_done_tick never arrives.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rr_pick.sv | 42 ++++
 rtl/uart_tx_arbiter.sv | 124 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the tx arbiter state encoding, the default byte width and the
// baud/oversample constants used by the baud generator, uart_rx and uart_tx.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } tx_arb_state_t;

  localparam int DATA_W_DEF       = 8;

  localparam int BAUD_RATE        = 19200;
  localparam int CLK_PER_OVS_TICK = 164;
  localparam int OVERSAMPLE       = 16;
  localparam int FRAME_BITS       = 10;
  // One full frame in clk cycles; the arbiter watchdog must exceed this.
  localparam int CLK_PER_FRAME    = CLK_PER_OVS_TICK * OVERSAMPLE * FRAME_BITS;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin selector.
// Scans req_valid starting just after 'last' (wrapping modulo N_REQ) and
// returns the first asserted index.
//   req_valid  in   N_REQ  per-requester request flags
//   last       in   IDX_W  index served most recently
//   winner     out  IDX_W  selected requester (0 when none valid)
//   any_valid  out  1      at least one request is pending
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] winner,
  output logic             any_valid
);

  localparam logic [IDX_W:0] N_REQ_W = (IDX_W + 1)'(N_REQ);

  logic [IDX_W:0] cand;

  // Walk offsets from farthest to nearest so the nearest valid requester
  // after 'last' is the one left standing.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = {1'b0, last} + (IDX_W + 1)'(k);
      if (cand >= N_REQ_W) begin
        cand = cand - N_REQ_W;
      end
      if (req_valid[cand[IDX_W-1:0]]) begin
        winner    = cand[IDX_W-1:0];
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer among N_REQ requesters.
// Accepts one byte at a time, pulses tx_start, then waits for tx_done_tick;
// a watchdog aborts the frame if the done tick never arrives.
//   clk, reset     clock / async active-high reset
//   req_valid      in   N_REQ         byte available per requester
//   req_data       in   N_REQ*DATA_W  requester i byte at [i*DATA_W +: DATA_W]
//   req_ready      out  N_REQ         one-hot accept, only in IDLE
//   tx_start       out  1             one-cycle start pulse to uart_tx
//   tx_data        out  DATA_W        byte for uart_tx, held for the frame
//   tx_done_tick   in   1             frame complete from uart_tx
//   busy           out  1             state != IDLE
//   grant_id       out  IDX_W         owner of current/last frame
//   timeout_err    out  1             one-cycle pulse on watchdog abort
//
// state      | meaning
// IDLE       | waiting for a request; accepts the round-robin winner
// START      | tx_start high for this cycle; watchdog cleared
// WAIT_DONE  | frame in flight; leaves on done tick or watchdog limit
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 32767,
  parameter int CNT_W   = 16,
  localparam int IDX_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    tx_start,
  output logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_done_tick,
  output logic                    busy,
  output logic [IDX_W-1:0]        grant_id,
  output logic                    timeout_err
);

  tx_arb_state_t    state_q, state_d;
  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] winner;
  logic             any_valid;
  logic [CNT_W-1:0] wd_cnt;
  logic [N_REQ-1:0] ready_c;
  logic             accept;

  uart_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_valid (req_valid),
    .last      (last_q),
    .winner    (winner),
    .any_valid (any_valid)
  );

  assign accept = (state_q == ST_IDLE) && any_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ready_c     = '0;
    timeout_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          ready_c[winner] = 1'b1;
          state_d         = ST_START;
        end
      end
      ST_START: begin
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // A done tick on the watchdog's last cycle is a good frame.
        if (tx_done_tick) begin
          state_d = ST_IDLE;
        end else if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
          timeout_err = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Ready is combinational from state, so gate it explicitly during reset.
  assign req_ready = reset ? '0 : ready_c;
  assign busy      = (state_q != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_start <= 1'b0;
      tx_data  <= '0;
      grant_id <= '0;
      last_q   <= IDX_W'(N_REQ - 1);
      wd_cnt   <= '0;
    end else begin
      tx_start <= accept;
      if (accept) begin
        tx_data  <= req_data[int'(winner) * DATA_W +: DATA_W];
        grant_id <= winner;
        last_q   <= winner;
      end
      if (state_q == ST_START) begin
        wd_cnt <= '0;
      end else if (state_q == ST_WAIT_DONE) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: randomized and directed requester traffic,
// a cycle-level reference model of the arbitration rules, and a scoreboard
// monitor that checks every frame presented on tx_start.
module tb_uart_tx_arbiter;

  localparam int N_REQ   = 4;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 100;
  localparam int CNT_W   = 16;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    tx_start;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_done_tick;
  logic                    busy;
  logic [1:0]              grant_id;
  logic                    timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ   (N_REQ),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_done_tick (tx_done_tick),
    .busy         (busy),
    .grant_id     (grant_id),
    .timeout_err  (timeout_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- requesters ----------------
  logic [7:0]       rq[N_REQ][$];
  logic [N_REQ-1:0] pulse_v = '0;
  logic [7:0]       pulse_d = 8'h00;

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N_REQ; i++) s += rq[i].size();
    return s;
  endfunction

  initial begin
    logic [N_REQ-1:0] hs;
    req_valid = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N_REQ; i++) begin
        if (hs[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          req_valid[i] = 1'b1;
          req_data[i*DATA_W +: DATA_W] = rq[i][0];
        end else if (pulse_v[i]) begin
          req_valid[i] = 1'b1;
          req_data[i*DATA_W +: DATA_W] = pulse_d;
        end else begin
          req_valid[i] = 1'b0;
          req_data[i*DATA_W +: DATA_W] = 8'($urandom);
        end
      end
    end
  end

  // ---------------- uart_tx stand-in ----------------
  // 0: done after 1..20 cycles, 1: never, 2: exactly on the watchdog limit cycle
  int done_mode  = 0;
  int stray_cnt  = 0;
  int stray_done = 0;

  initial begin
    int d;
    tx_done_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && !reset) begin
        case (done_mode)
          0:       d = $urandom_range(1, 20);
          2:       d = TIMEOUT;
          default: d = 0;
        endcase
        if (d > 0) begin
          repeat (d) @(posedge clk);
          #1 tx_done_tick = 1'b1;
          @(posedge clk);
          #1 tx_done_tick = 1'b0;
        end
      end else if (stray_done < stray_cnt && !busy && !reset) begin
        stray_done++;
        @(posedge clk);
        #1 tx_done_tick = 1'b1;
        @(posedge clk);
        #1 tx_done_tick = 1'b0;
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    int         id;
    logic [7:0] data;
  } frame_t;

  frame_t exp_q[$];
  int     cyc     = 0;
  bit     m_free  = 1'b1;
  int     m_last  = N_REQ - 1;
  int     m_start = -1000;

  always @(negedge clk) begin
    bit               was_busy;
    bit               exp_to;
    logic [N_REQ-1:0] exp_ready;
    int               win;
    int               idx;
    cyc++;
    if (reset) begin
      m_free  = 1'b1;
      m_last  = N_REQ - 1;
      m_start = -1000;
      exp_q.delete();
      check("reset_outputs",
            {15'd0, req_ready, tx_start, tx_data, busy, grant_id, timeout_err}, 32'd0);
    end else begin
      was_busy  = !m_free;
      exp_ready = '0;
      exp_to    = 1'b0;
      check("tx_start_timing", tx_start, was_busy && (cyc == m_start));
      check("busy", busy, was_busy);
      if (m_free) begin
        win = -1;
        for (int k = 1; k <= N_REQ; k++) begin
          idx = (m_last + k) % N_REQ;
          if (win < 0 && req_valid[idx]) win = idx;
        end
        if (win >= 0) begin
          exp_ready[win] = 1'b1;
          exp_q.push_back('{id: win, data: req_data[win*DATA_W +: DATA_W]});
          m_last  = win;
          m_free  = 1'b0;
          m_start = cyc + 1;
        end
      end else if (cyc > m_start) begin
        if (tx_done_tick) begin
          m_free = 1'b1;
        end else if (cyc == m_start + TIMEOUT) begin
          exp_to = 1'b1;
          m_free = 1'b1;
        end
      end
      check("req_ready", req_ready, exp_ready);
      check("timeout_err", timeout_err, exp_to);
    end
  end

  // ---------------- scoreboard monitor ----------------
  frame_t cur;
  bit     have_cur = 1'b0;

  always @(negedge clk) begin
    frame_t e;
    if (reset) begin
      have_cur = 1'b0;
    end else begin
      if (tx_start) begin
        check("frame_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("start_grant_id", grant_id, e.id);
          check("start_tx_data", tx_data, e.data);
          cur      = e;
          have_cur = 1'b1;
        end
      end
      if (tx_done_tick && busy && have_cur) begin
        check("done_grant_id", grant_id, cur.id);
        check("done_tx_data", tx_data, cur.data);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    int  n  = 0;
    bit  ok = 1'b0;
    while (!ok && n < 4000) begin
      @(negedge clk);
      n++;
      ok = !busy && (req_valid == '0) && (pending() == 0);
    end
    check("drain_in_time", ok, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("frame_started", busy, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r;
    int nb;
    int ri;
    int guard;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // all four continuously valid: expect 0,1,2,3,0
    for (int i = 0; i < N_REQ; i++) rq[i].push_back(8'(8'h10 + i));
    rq[0].push_back(8'h14);
    wait_idle();

    // single requester
    rq[2].push_back(8'h41);
    wait_idle();

    // watchdog abort, then a normal frame
    done_mode = 1;
    rq[1].push_back(8'hA5);
    wait_idle();
    done_mode = 0;
    rq[1].push_back(8'h5A);
    wait_idle();

    // done tick coincident with watchdog limit
    done_mode = 2;
    rq[3].push_back(8'hC3);
    wait_idle();
    done_mode = 0;

    // reset during WAIT_DONE with others waiting; requester 0 must win after
    done_mode = 1;
    rq[2].push_back(8'h22);
    wait_busy();
    rq[0].push_back(8'h30);
    rq[1].push_back(8'h31);
    rq[3].push_back(8'h33);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    done_mode = 0;
    #1 reset = 1'b0;
    wait_idle();

    // stray done tick while idle
    stray_cnt++;
    repeat (6) @(posedge clk);
    #1;

    // request pulsed and withdrawn while busy
    done_mode = 1;
    rq[0].push_back(8'h99);
    wait_busy();
    pulse_d    = 8'h77;
    pulse_v[3] = 1'b1;
    repeat (3) @(posedge clk);
    #1 pulse_v[3] = 1'b0;
    done_mode = 0;
    wait_idle();

    // randomized traffic
    for (int it = 0; it < 250; it++) begin
      r = $urandom_range(0, 19);
      done_mode = (r == 0) ? 2 : ((r == 1) ? 1 : 0);
      repeat ($urandom_range(0, 6)) @(posedge clk);
      #1;
      guard = 0;
      while (pending() > 3 && guard < 2000) begin
        @(posedge clk);
        guard++;
      end
      #1;
      nb = $urandom_range(1, 3);
      for (int j = 0; j < nb; j++) begin
        ri = $urandom_range(0, N_REQ - 1);
        rq[ri].push_back(8'($urandom));
      end
      if ($urandom_range(0, 9) == 0) stray_cnt++;
    end
    done_mode = 0;
    wait_idle();
    repeat (5) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    total++;
    bad++;
    $display("FAIL global_time_limit: simulation still running at %0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
